hack_cpu_mc: RTL and testbench
==============================

Name: hack_cpu_mc

Overview:
- Multi-cycle, parametrised Hack CPU core. It replaces the single-cycle core that assumes zero-latency memories.
- Fetches from instruction memory and accesses data memory through req/ack handshakes, so wait-state ROM/RAM and memory-mapped peripherals can be attached.
- Sits between the instruction ROM and the data RAM/IO bus at the top of the computer.
- Datapath width is generalised. Instruction encoding stays the standard 16-bit Hack format.

Parameters:
- DATA_W, 16, width of A, D, ALU and data bus; must be >= 16.
- ADDR_W, 15, data memory address width; must be <= DATA_W.
- PC_W, 16, program counter / instruction address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  access complete; dmem_rdata valid on reads
- dmem_rdata  in  DATA_W  read data (M)
- pc  out  PC_W  current program counter
- a_reg  out  DATA_W  A register (debug)
- d_reg  out  DATA_W  D register (debug)
- halted  out  1  halt detected (optional feature)

Behaviour:
- Reset (synchronous, active-high): state=FETCH, pc=0, A=0, D=0, IR=0, halted=0.
- Reset outputs: imem_req/dmem_req/dmem_we are decoded from state, so imem_req=1 in the first post-reset cycle and dmem_req=0.
- FSM states: FETCH, DECODE, MEM_RD, EXEC, MEM_WR.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: IR<=imem_rdata, go to DECODE.
  - Hold req until ack; ack may arrive the same cycle as req.
- DECODE, A-instruction (IR[15]=0): A<=zero-extended IR[14:0], pc<=pc+1, go to FETCH.
- DECODE, C-instruction with IR[12]=1: go to MEM_RD. Otherwise go to EXEC.
- MEM_RD: dmem_req=1, dmem_we=0, dmem_addr=A[ADDR_W-1:0]. On dmem_ack: MDR<=dmem_rdata, go to EXEC.
- EXEC, ALU: x=D; y=MDR if IR[12] else A. Control bits zx,nx,zy,ny,f,no = IR[11:6]. Standard Hack ALU over DATA_W bits with wrap-around add. zr = result==0; ng = result MSB.
- EXEC, writebacks: all use pre-instruction A and D values.
  - ALUR<=result and WADDR<=old A[ADDR_W-1:0].
  - IR[5]: A<=result.
  - IR[4]: D<=result.
- EXEC, jump: jmp = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&!ng&!zr).
  - pc<=old A[PC_W-1:0] if jmp, else pc+1.
  - Next state: MEM_WR if IR[3], else FETCH.
- MEM_WR: dmem_req=1, dmem_we=1, dmem_addr=WADDR, dmem_wdata=ALUR. On dmem_ack, go to FETCH.
- Latency with zero-wait memories:
  - A-instr 2 cycles.
  - C-instr 3 cycles.
  - +1 if a=1 (read).
  - +1 if d3=1 (write).
  - Each memory wait cycle adds 1.
- dmem_addr, dmem_wdata and dmem_we are stable while dmem_req=1. dmem_we=0 whenever dmem_req=0.
- pc wraps modulo 2^PC_W.
- Reset mid-transaction: request is abandoned. req drops the cycle after the reset edge; a late ack is ignored in FETCH/DECODE/EXEC.
- Reset dominates ack in the same cycle.
- Unused IR bits 14:13 of a C-instruction are ignored.

Optional Feature:
- Macro: HACK_CPU_HALT_DET_EN.
- With the macro defined: in EXEC, a C-instruction with IR[2:0]=3'b111 and old A[PC_W-1:0]==pc sets halted=1 and moves the FSM to a sticky HALT state. HALT issues no requests and holds pc, A and D. Only reset clears it.
  - This catches the canonical "@END; 0;JMP" end loop.
  - If IR[3] is also set, MEM_WR completes first, then HALT is entered.
- Without the macro: halted is tied 0, no HALT state exists, and the loop executes indefinitely.

Test Plan:
- Zero-wait memories, program "@21; D=A; @5; M=D" -> after 2+3+2+4=11 cycles: A=5, D=21, one dmem write addr=5 data=21, pc=4.
- D=7, "@9; D;JGT" -> pc=9.
  - Same with D=0 -> pc=2.
  - D=-1 with ";JLT" -> taken.
  - D=0 with ";JEQ" -> taken.
- dmem_ack delayed 3 cycles on "D=M" with mem[A]=0x1234 -> dmem_req held 4 cycles with stable address; D=0x1234; instruction takes 7 cycles.
- DATA_W=32: "@32767; D=A; D=D+1; D=D+D" -> D=0x00010000, with no 16-bit wrap.
- reset asserted during MEM_RD with ack still pending -> next cycle state FETCH, pc=0, A=0, D=0, dmem_req=0; ack arriving afterward causes no register change.
- HACK_CPU_HALT_DET_EN, program "@3; 0;JMP" at pc=2..3 -> halted=1 after EXEC of pc=3, no further imem_req. Without the macro, pc loops 3→3 forever.

Source files
------------

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU core with req/ack instruction and data memory ports.
// Optional halt detection of the "@X; 0;JMP" self-loop is enabled by defining HACK_CPU_HALT_DET_EN.
module hack_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] d_reg,
  output logic              halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
`ifdef HACK_CPU_HALT_DET_EN
  localparam logic [2:0] S_HALT   = 3'd5;
`endif

  logic [2:0]              state;
  logic [15:0]             ir;
  logic [DATA_W-1:0]       mdr;
  logic [DATA_W-1:0]       alur;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       a_imm;
  logic [DATA_W-1:0]       alu_y;
  logic [DATA_W-1:0]       alu_res;
  logic [DATA_W+PC_W-1:0]  a_ext;
  logic [PC_W-1:0]         a_pc;
  logic [PC_W-1:0]         pc_inc;
  logic                    zr;
  logic                    ng;
  logic                    jmp;
  logic                    unused_ext;
`ifdef HACK_CPU_HALT_DET_EN
  logic                    halt_hit;
  logic                    halt_pend;
`endif

  function automatic logic [DATA_W-1:0] hack_alu(
    input logic [DATA_W-1:0] x_in,
    input logic [DATA_W-1:0] y_in,
    input logic [5:0]        ctl
  );
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] r;
    x = ctl[5] ? {DATA_W{1'b0}} : x_in;
    x = ctl[4] ? ~x : x;
    y = ctl[3] ? {DATA_W{1'b0}} : y_in;
    y = ctl[2] ? ~y : y;
    r = ctl[1] ? (x + y) : (x & y);
    r = ctl[0] ? ~r : r;
    return r;
  endfunction

  assign a_imm      = {{(DATA_W-15){1'b0}}, ir[14:0]};
  assign alu_y      = ir[12] ? mdr : a_reg;
  assign alu_res    = hack_alu(d_reg, alu_y, ir[11:6]);
  assign zr         = (alu_res == {DATA_W{1'b0}});
  assign ng         = alu_res[DATA_W-1];
  assign jmp        = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
  // Zero-extend before slicing so PC_W may exceed DATA_W.
  assign a_ext      = {{PC_W{1'b0}}, a_reg};
  assign a_pc       = a_ext[PC_W-1:0];
  assign unused_ext = ^a_ext[DATA_W+PC_W-1:PC_W];
  assign pc_inc     = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign imem_addr  = pc;
  assign dmem_wdata = alur;
`ifdef HACK_CPU_HALT_DET_EN
  assign halt_hit   = (ir[2:0] == 3'b111) && (a_pc == pc);
`else
  assign halted     = 1'b0;
`endif

  // Memory handshake strobes decoded from the current state.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_addr = a_reg[ADDR_W-1:0];
    case (state)
      S_FETCH:  imem_req = 1'b1;
      S_MEM_RD: dmem_req = 1'b1;
      S_MEM_WR: begin
        dmem_req  = 1'b1;
        dmem_we   = 1'b1;
        dmem_addr = waddr;
      end
      default:  imem_req = 1'b0;
    endcase
  end

  // Sequencer and architectural registers; EXEC reads pre-instruction A and D.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= {PC_W{1'b0}};
      a_reg <= {DATA_W{1'b0}};
      d_reg <= {DATA_W{1'b0}};
      ir    <= 16'h0000;
      mdr   <= {DATA_W{1'b0}};
      alur  <= {DATA_W{1'b0}};
      waddr <= {ADDR_W{1'b0}};
`ifdef HACK_CPU_HALT_DET_EN
      halted    <= 1'b0;
      halt_pend <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!ir[15]) begin
            a_reg <= a_imm;
            pc    <= pc_inc;
            state <= S_FETCH;
          end else if (ir[12]) begin
            state <= S_MEM_RD;
          end else begin
            state <= S_EXEC;
          end
        end
        S_MEM_RD: begin
          if (dmem_ack) begin
            mdr   <= dmem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alur  <= alu_res;
          waddr <= a_reg[ADDR_W-1:0];
          if (ir[5]) a_reg <= alu_res;
          if (ir[4]) d_reg <= alu_res;
          pc <= jmp ? a_pc : pc_inc;
`ifdef HACK_CPU_HALT_DET_EN
          halt_pend <= halt_hit;
          if (ir[3]) begin
            state <= S_MEM_WR;
          end else if (halt_hit) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
`else
          state <= ir[3] ? S_MEM_WR : S_FETCH;
`endif
        end
        S_MEM_WR: begin
          if (dmem_ack) begin
`ifdef HACK_CPU_HALT_DET_EN
            if (halt_pend) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
`else
            state <= S_FETCH;
`endif
          end
        end
`ifdef HACK_CPU_HALT_DET_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: 16-bit core with wait-state data memory, plus a
// 32-bit instance sharing the same program ROM.
module tb_hack_cpu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [15:0] imem_addr, imem_rdata, pc, a_reg, d_reg, dmem_wdata, dmem_rdata;
  logic [14:0] dmem_addr;

  logic        imem32_req, imem32_ack, dmem32_req, dmem32_we, dmem32_ack, halted32;
  logic [15:0] imem32_addr, imem32_rdata, pc32;
  logic [14:0] dmem32_addr;
  logic [31:0] dmem32_wdata, dmem32_rdata, a32, d32;

  logic [15:0] rom [0:15];
  logic        imem_stall = 1'b0;
  logic        force_dack = 1'b0;
  int          dwait = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic [14:0] last_wa = 15'd0;
  logic [15:0] last_wd = 16'd0;
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_base;

  always #5 clk = ~clk;

  assign imem_ack     = imem_req && !imem_stall;
  assign imem_rdata   = rom[imem_addr[3:0]];
  assign dmem_ack     = (dmem_req && (wcnt >= dwait)) || force_dack;
  assign dmem_rdata   = (dmem_addr == 15'd100) ? 16'h1234 : 16'h0000;
  assign imem32_ack   = imem32_req;
  assign imem32_rdata = rom[imem32_addr[3:0]];
  assign dmem32_ack   = dmem32_req;
  assign dmem32_rdata = 32'h0000_0000;

  // Wait-state counter and write recorder for the 16-bit data port.
  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (dmem_req && dmem_we && dmem_ack) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= dmem_addr;
      last_wd <= dmem_wdata;
    end
  end

  hack_cpu_mc u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .halted(halted)
  );

  hack_cpu_mc #(.DATA_W(32), .ADDR_W(15), .PC_W(16)) u_dut32 (
    .clk(clk), .reset(reset),
    .imem_req(imem32_req), .imem_addr(imem32_addr), .imem_ack(imem32_ack), .imem_rdata(imem32_rdata),
    .dmem_req(dmem32_req), .dmem_we(dmem32_we), .dmem_addr(dmem32_addr), .dmem_wdata(dmem32_wdata),
    .dmem_ack(dmem32_ack), .dmem_rdata(dmem32_rdata),
    .pc(pc32), .a_reg(a32), .d_reg(d32), .halted(halted32)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // Jump program: load D via rom[0..1], @9, then conditional jump; fixed cycle count.
  task automatic jump_case(input string tag, input logic [15:0] i0, input logic [15:0] i1,
                           input logic [15:0] i2, input logic [15:0] i3, input int cyc,
                           input logic [15:0] exp_pc);
    clear_rom();
    rom[0] = i0; rom[1] = i1; rom[2] = i2; rom[3] = i3;
    do_reset();
    run(cyc);
    check_eq(tag, pc, exp_pc);
  endtask

  initial begin
    reset = 1'b1;
    clear_rom();

    // Store program: @21; D=A; @5; M=D
    rom[0] = 16'h0015; rom[1] = 16'hEC10; rom[2] = 16'h0005; rom[3] = 16'hE308;
    do_reset();
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_a", a_reg, 16'h0000);
    check_eq("rst_d", d_reg, 16'h0000);
    check_eq("rst_imem_req", imem_req, 1);
    check_eq("rst_dmem_req", dmem_req, 0);
    check_eq("rst_halted", halted, 0);
    wr_base = wr_cnt;
    run(2);
    check_eq("a_instr_2cyc", a_reg, 16'd21);
    run(9);
    check_eq("st_a", a_reg, 16'd5);
    check_eq("st_d", d_reg, 16'd21);
    check_eq("st_pc", pc, 16'd4);
    check_eq("st_wr_cnt", wr_cnt - wr_base, 1);
    check_eq("st_wr_addr", last_wa, 15'd5);
    check_eq("st_wr_data", last_wd, 16'd21);

    // Conditional jumps.
    jump_case("jgt_taken",   16'h0007, 16'hEC10, 16'h0009, 16'hE301, 10, 16'd9);
    check_eq("jgt_d", d_reg, 16'd7);
    jump_case("jgt_not_d0",  16'h0000, 16'hEC10, 16'h0009, 16'hE301, 10, 16'd4);
    jump_case("jlt_taken",   16'hEE90, 16'h0009, 16'hE304, 16'h0000, 8, 16'd9);
    check_eq("jlt_d", d_reg, 16'hFFFF);
    jump_case("jeq_taken",   16'hEA90, 16'h0009, 16'hE302, 16'h0000, 8, 16'd9);
    jump_case("jlt_not_d1",  16'hEFD0, 16'h0009, 16'hE304, 16'h0000, 8, 16'd3);

    // D=M with a 3-cycle wait on the data port.
    clear_rom();
    rom[0] = 16'h0064; rom[1] = 16'hFC10;
    dwait = 3;
    do_reset();
    run(4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rd_req_%0d", k), dmem_req, 1);
      check_eq($sformatf("rd_we_%0d", k), dmem_we, 0);
      check_eq($sformatf("rd_addr_%0d", k), dmem_addr, 15'd100);
      run(1);
    end
    check_eq("rd_req_drop", dmem_req, 0);
    check_eq("rd_d_pending", d_reg, 16'h0000);
    run(1);
    check_eq("rd_d", d_reg, 16'h1234);
    check_eq("rd_pc", pc, 16'd2);
    check_eq("rd_fetch", imem_req, 1);

    // Reset while MEM_RD waits; reset and a late ack land together, then acks keep arriving.
    dwait = 20;
    do_reset();
    run(5);
    check_eq("mr_in_rd", dmem_req, 1);
    reset = 1'b1;
    force_dack = 1'b1;
    run(1);
    check_eq("mr_imem_req", imem_req, 1);
    check_eq("mr_dmem_req", dmem_req, 0);
    check_eq("mr_pc", pc, 16'h0000);
    check_eq("mr_a", a_reg, 16'h0000);
    check_eq("mr_d", d_reg, 16'h0000);
    imem_stall = 1'b1;
    reset = 1'b0;
    run(3);
    check_eq("late_ack_d", d_reg, 16'h0000);
    check_eq("late_ack_a", a_reg, 16'h0000);
    check_eq("late_ack_pc", pc, 16'h0000);
    check_eq("late_ack_dreq", dmem_req, 0);
    check_eq("late_ack_we", dmem_we, 0);
    check_eq("late_ack_fetch", imem_req, 1);
    force_dack = 1'b0;
    imem_stall = 1'b0;
    dwait = 0;

    // @32767; D=A; AD=D+1; D=D+A -> 0x10000 at 32 bits, wraps to 0 at 16 bits.
    clear_rom();
    rom[0] = 16'h7FFF; rom[1] = 16'hEC10; rom[2] = 16'hE7F0; rom[3] = 16'hE090;
    do_reset();
    run(11);
    check_eq("w32_d", d32, 32'h0001_0000);
    check_eq("w32_a", a32, 32'h0000_8000);
    check_eq("w32_pc", pc32, 16'd4);
    check_eq("w16_d_wrap", d_reg, 16'h0000);
    check_eq("w16_a", a_reg, 16'h8000);

    // End loop: @7; @8; @3; 0;JMP at pc 2..3.
    clear_rom();
    rom[0] = 16'h0007; rom[1] = 16'h0008; rom[2] = 16'h0003; rom[3] = 16'hEA87;
    do_reset();
    run(8);
    check_eq("loop_pre_halt", halted, 0);
    run(1);
    check_eq("loop_pc", pc, 16'd3);
    check_eq("loop_a", a_reg, 16'd3);
`ifdef HACK_CPU_HALT_DET_EN
    check_eq("halt_flag", halted, 1);
    check_eq("halt_no_req", imem_req, 0);
    run(10);
    check_eq("halt_sticky", halted, 1);
    check_eq("halt_no_req2", imem_req, 0);
    check_eq("halt_pc_hold", pc, 16'd3);
`else
    check_eq("nohalt_flag", halted, 0);
    check_eq("nohalt_fetch", imem_req, 1);
    run(10);
    check_eq("nohalt_pc", pc, 16'd3);
    check_eq("nohalt_flag2", halted, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
